// File: rtl/gb_video_pkg.sv
// Shared definitions for the Game Boy video path.
//   frame_writer_state_e : states of ppu_frame_writer
//   GB_LCD_WIDTH/HEIGHT  : native LCD geometry
//   GB_PIXEL_BITS        : native pixel depth (2-bit shade)
//   fb_addr_width()      : framebuffer address width {bank?, y, x}
package gb_video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VBLANK,
        ACTIVE,
        CLEAR
    } frame_writer_state_e;

    localparam int unsigned GB_LCD_WIDTH  = 160;
    localparam int unsigned GB_LCD_HEIGHT = 144;
    localparam int unsigned GB_PIXEL_BITS = 2;

    function automatic int unsigned fb_addr_width(input int unsigned double_buffer,
                                                  input int unsigned y_bits,
                                                  input int unsigned x_bits);
        return double_buffer + y_bits + x_bits;
    endfunction

endpackage

// File: rtl/ppu_frame_writer_if.sv
// Framebuffer write bus.
//   fb_write_en   : write strobe
//   fb_write_addr : {bank?, y, x}
//   fb_write_data : pixel value
// master = frame writer (drives), slave = framebuffer RAM (receives).
interface ppu_frame_writer_if #(
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned PIXEL_BITS = 2
);
    logic                  fb_write_en;
    logic [ADDR_W-1:0]     fb_write_addr;
    logic [PIXEL_BITS-1:0] fb_write_data;

    modport master (output fb_write_en, output fb_write_addr, output fb_write_data);
    modport slave  (input  fb_write_en, input  fb_write_addr, input  fb_write_data);
endinterface

// File: rtl/ppu_frame_writer.sv
// Converts the PPU pixel stream into framebuffer RAM writes.
// Ports:
//   clock, reset      : core clock, synchronous active-high reset
//   ppu_pixel/valid   : pixel stream
//   ppu_hblank/vblank : line/frame level markers (rising edges are events)
//   ppu_lcdEnable     : LCD on
//   fb                : framebuffer write bus (master)
//   front_buffer      : bank the video reader displays
//   frame_done        : one-cycle pulse per swap / completed frame
//   frame_count       : completed frames (wraps)
//   err_overflow      : sticky, pixel outside the visible area
//   err_short_frame   : sticky, vblank before all lines were seen
module ppu_frame_writer
    import gb_video_pkg::*;
#(
    parameter int unsigned         WIDTH            = GB_LCD_WIDTH,
    parameter int unsigned         HEIGHT           = GB_LCD_HEIGHT,
    parameter int unsigned         X_BITS           = 8,
    parameter int unsigned         Y_BITS           = 8,
    parameter int unsigned         PIXEL_BITS       = GB_PIXEL_BITS,
    parameter int unsigned         DOUBLE_BUFFER    = 1,
    parameter int unsigned         CLEAR_ON_DISABLE = 1,
    parameter logic [PIXEL_BITS-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PIXEL_BITS-1:0] ppu_pixel,
    input  logic                  ppu_valid,
    input  logic                  ppu_hblank,
    input  logic                  ppu_vblank,
    input  logic                  ppu_lcdEnable,
    ppu_frame_writer_if.master    fb,
    output logic                  front_buffer,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic                  err_overflow,
    output logic                  err_short_frame
);

    localparam int unsigned ADDR_W = fb_addr_width(DOUBLE_BUFFER, Y_BITS, X_BITS);

    // Counters are one bit wider than the address fields so they can hold WIDTH/HEIGHT.
    localparam logic [X_BITS:0] X_END  = (X_BITS + 1)'(WIDTH);
    localparam logic [X_BITS:0] X_LAST = (X_BITS + 1)'(WIDTH - 1);
    localparam logic [Y_BITS:0] Y_END  = (Y_BITS + 1)'(HEIGHT);

    localparam frame_writer_state_e DISABLE_STATE = (CLEAR_ON_DISABLE != 0) ? CLEAR : IDLE;

    frame_writer_state_e state_q, state_d;
    logic [X_BITS:0]       x_q, x_d;
    logic [Y_BITS:0]       y_q, y_d;
    logic                  hb_q, hb_prev_q, vb_q, vb_prev_q;
    logic                  front_q, front_d;
    logic                  done_q, done_d;
    logic [15:0]           count_q, count_d;
    logic                  eov_q, eov_d;
    logic                  esf_q, esf_d;
    logic                  wen_q, wen_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic [PIXEL_BITS-1:0] wdata_q, wdata_d;

    logic hb_rise, vb_rise, back;

    assign hb_rise = hb_q & ~hb_prev_q;
    assign vb_rise = vb_q & ~vb_prev_q;
    assign back    = ~front_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        front_d = front_q;
        done_d  = 1'b0;
        count_d = count_q;
        eov_d   = eov_q;
        esf_d   = esf_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (ppu_lcdEnable) state_d = WAIT_VBLANK;
            end

            WAIT_VBLANK: begin
                if (!ppu_lcdEnable) begin
                    state_d = DISABLE_STATE;
                    x_d     = '0;
                    y_d     = '0;
                end else if (vb_rise) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                end
            end

            ACTIVE: begin
                if (!ppu_lcdEnable) begin
                    state_d = DISABLE_STATE;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    // Pixel is placed at the old (x,y) before any row advance this cycle.
                    if (ppu_valid) begin
                        if (x_q < X_END && y_q < Y_END) begin
                            wen_d   = 1'b1;
                            waddr_d = ADDR_W'({back, y_q[Y_BITS-1:0], x_q[X_BITS-1:0]});
                            wdata_d = ppu_pixel;
                            x_d     = x_q + 1'b1;
                        end else begin
                            eov_d = 1'b1;
                        end
                    end
                    if (hb_rise) begin
                        x_d = '0;
                        if (y_q < Y_END) y_d = y_q + 1'b1;
                    end
                    if (vb_rise) begin
                        if (y_q == Y_END) begin
                            if (DOUBLE_BUFFER != 0) front_d = ~front_q;
                            done_d  = 1'b1;
                            count_d = count_q + 16'd1;
                        end else begin
                            esf_d = 1'b1;
                        end
                        x_d = '0;
                        y_d = '0;
                    end else if (vb_q) begin
                        x_d = '0;
                        y_d = '0;
                    end
                end
            end

            CLEAR: begin
                // y reaching HEIGHT marks the sweep as finished; swap one cycle later.
                if (y_q < Y_END) begin
                    wen_d   = 1'b1;
                    waddr_d = ADDR_W'({back, y_q[Y_BITS-1:0], x_q[X_BITS-1:0]});
                    wdata_d = CLEAR_VALUE;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end else begin
                    if (DOUBLE_BUFFER != 0) front_d = ~front_q;
                    done_d  = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = ppu_lcdEnable ? WAIT_VBLANK : IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            hb_q      <= 1'b0;
            hb_prev_q <= 1'b0;
            vb_q      <= 1'b0;
            vb_prev_q <= 1'b0;
            front_q   <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
            eov_q     <= 1'b0;
            esf_q     <= 1'b0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hb_q      <= ppu_hblank;
            hb_prev_q <= hb_q;
            vb_q      <= ppu_vblank;
            vb_prev_q <= vb_q;
            front_q   <= front_d;
            done_q    <= done_d;
            count_q   <= count_d;
            eov_q     <= eov_d;
            esf_q     <= esf_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign fb.fb_write_en   = wen_q;
    assign fb.fb_write_addr = waddr_q;
    assign fb.fb_write_data = wdata_q;
    assign front_buffer     = front_q;
    assign frame_done       = done_q;
    assign frame_count      = count_q;
    assign err_overflow     = eov_q;
    assign err_short_frame  = esf_q;

endmodule

// File: tb/tb_ppu_frame_writer.sv
// Bench for ppu_frame_writer: a double-buffered and a single-buffered instance
// share one stimulus stream; a behavioural model predicts every cycle's outputs.
module tb_ppu_frame_writer;
    import gb_video_pkg::*;

    localparam int unsigned W = GB_LCD_WIDTH;
    localparam int unsigned H = GB_LCD_HEIGHT;
    localparam int unsigned N = W * H;
    localparam int M_IDLE = 0, M_WAIT = 1, M_ACTIVE = 2, M_CLEAR = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] ppu_pixel = 2'd0;
    logic       ppu_valid = 1'b0, ppu_hblank = 1'b0, ppu_vblank = 1'b0, ppu_lcdEnable = 1'b0;

    logic        front1, done1, eov1, esf1, front2, done2, eov2, esf2;
    logic [15:0] count1, count2;

    ppu_frame_writer_if #(.ADDR_W(17), .PIXEL_BITS(2)) fb1 ();
    ppu_frame_writer_if #(.ADDR_W(16), .PIXEL_BITS(2)) fb2 ();

    ppu_frame_writer #(.DOUBLE_BUFFER(1), .CLEAR_ON_DISABLE(1), .CLEAR_VALUE(2'd3)) dut1 (
        .clock(clock), .reset(reset), .ppu_pixel(ppu_pixel), .ppu_valid(ppu_valid),
        .ppu_hblank(ppu_hblank), .ppu_vblank(ppu_vblank), .ppu_lcdEnable(ppu_lcdEnable),
        .fb(fb1), .front_buffer(front1), .frame_done(done1), .frame_count(count1),
        .err_overflow(eov1), .err_short_frame(esf1)
    );

    ppu_frame_writer #(.DOUBLE_BUFFER(0), .CLEAR_ON_DISABLE(1), .CLEAR_VALUE(2'd3)) dut2 (
        .clock(clock), .reset(reset), .ppu_pixel(ppu_pixel), .ppu_valid(ppu_valid),
        .ppu_hblank(ppu_hblank), .ppu_vblank(ppu_vblank), .ppu_lcdEnable(ppu_lcdEnable),
        .fb(fb2), .front_buffer(front2), .frame_done(done2), .frame_count(count2),
        .err_overflow(eov2), .err_short_frame(esf2)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0, n_fail = 0;
    int n_wr = 0, n_wr3 = 0, n_done = 0;

    typedef struct {
        bit          en;
        bit          bank;
        int unsigned y;
        int unsigned x;
        logic [1:0]  data;
        bit          done;
        bit          front;
        logic [15:0] count;
        bit          eov;
        bit          esf;
    } exp_t;

    exp_t exp_o;

    // Model state
    int          mstate = M_IDLE;
    int unsigned mx = 0, my = 0, mcount = 0, cstart = 0;
    bit          mfront = 0, meov = 0, mesf = 0;
    bit          hb1 = 0, hb2 = 0, vb1 = 0, vb2 = 0;

    function automatic logic [1:0] pixval(input int unsigned x, input int unsigned y);
        return 2'(x ^ (y * 3));
    endfunction

    // Predicts the outputs visible after edge e from the inputs that edge samples.
    function automatic void model_edge(input int unsigned e);
        bit rh, rv, vlev;
        int unsigned y0, idx;
        exp_o.en = 0; exp_o.bank = 0; exp_o.y = 0; exp_o.x = 0; exp_o.data = 2'd0;
        exp_o.done = 0;
        rh   = hb1 && !hb2;
        rv   = vb1 && !vb2;
        vlev = vb1;
        if (reset) begin
            mstate = M_IDLE; mx = 0; my = 0; mfront = 0; mcount = 0; meov = 0; mesf = 0;
            hb1 = 0; hb2 = 0; vb1 = 0; vb2 = 0;
        end else begin
            hb2 = hb1; hb1 = ppu_hblank; vb2 = vb1; vb1 = ppu_vblank;
            case (mstate)
                M_IDLE: if (ppu_lcdEnable) mstate = M_WAIT;
                M_WAIT: begin
                    if (!ppu_lcdEnable) begin mstate = M_CLEAR; cstart = e; end
                    else if (rv) begin mstate = M_ACTIVE; mx = 0; my = 0; end
                end
                M_ACTIVE: begin
                    if (!ppu_lcdEnable) begin
                        mstate = M_CLEAR; cstart = e;
                    end else begin
                        y0 = my;
                        if (ppu_valid) begin
                            if (mx < W && my < H) begin
                                exp_o.en = 1; exp_o.bank = !mfront; exp_o.y = my; exp_o.x = mx;
                                exp_o.data = ppu_pixel; mx++;
                            end else meov = 1;
                        end
                        if (rh) begin mx = 0; if (my < H) my++; end
                        if (rv) begin
                            if (y0 == H) begin
                                mfront = !mfront; mcount = (mcount + 1) % 65536; exp_o.done = 1;
                            end else mesf = 1;
                            mx = 0; my = 0;
                        end else if (vlev) begin mx = 0; my = 0; end
                    end
                end
                default: begin
                    idx = e - cstart - 1;
                    if (idx < N) begin
                        exp_o.en = 1; exp_o.bank = !mfront; exp_o.y = idx / W;
                        exp_o.x = idx % W; exp_o.data = 2'd3;
                    end else begin
                        mfront = !mfront; exp_o.done = 1;
                        mstate = ppu_lcdEnable ? M_WAIT : M_IDLE;
                    end
                end
            endcase
        end
        exp_o.front = mfront;
        exp_o.count = 16'(mcount);
        exp_o.eov   = meov;
        exp_o.esf   = mesf;
    endfunction

    task automatic compare();
        logic [16:0] ea1;
        logic [15:0] ea2;
        bit bad1, bad2;
        ea1 = {exp_o.bank, 8'(exp_o.y), 8'(exp_o.x)};
        ea2 = {8'(exp_o.y), 8'(exp_o.x)};
        bad1 = (fb1.fb_write_en !== exp_o.en)
            || (exp_o.en && (fb1.fb_write_addr !== ea1 || fb1.fb_write_data !== exp_o.data))
            || done1 !== exp_o.done || front1 !== exp_o.front || count1 !== exp_o.count
            || eov1 !== exp_o.eov || esf1 !== exp_o.esf;
        bad2 = (fb2.fb_write_en !== exp_o.en)
            || (exp_o.en && (fb2.fb_write_addr !== ea2 || fb2.fb_write_data !== exp_o.data))
            || done2 !== exp_o.done || front2 !== 1'b0 || count2 !== exp_o.count
            || eov2 !== exp_o.eov || esf2 !== exp_o.esf;
        n_cmp += 2;
        if (bad1) begin
            n_fail++;
            $display("FAIL cycle_dbuf @%0d: got en=%b addr=%h data=%0d done=%b front=%b cnt=%0d ovf=%b short=%b; need en=%b addr=%h data=%0d done=%b front=%b cnt=%0d ovf=%b short=%b",
                     cyc, fb1.fb_write_en, fb1.fb_write_addr, fb1.fb_write_data, done1, front1,
                     count1, eov1, esf1, exp_o.en, ea1, exp_o.data, exp_o.done, exp_o.front,
                     exp_o.count, exp_o.eov, exp_o.esf);
        end
        if (bad2) begin
            n_fail++;
            $display("FAIL cycle_sbuf @%0d: got en=%b addr=%h data=%0d done=%b front=%b cnt=%0d ovf=%b short=%b; need en=%b addr=%h data=%0d done=%b front=0 cnt=%0d ovf=%b short=%b",
                     cyc, fb2.fb_write_en, fb2.fb_write_addr, fb2.fb_write_data, done2, front2,
                     count2, eov2, esf2, exp_o.en, ea2, exp_o.data, exp_o.done,
                     exp_o.count, exp_o.eov, exp_o.esf);
        end
        if (fb1.fb_write_en) begin
            n_wr++;
            if (fb1.fb_write_data == 2'd3) n_wr3++;
        end
        if (done1) n_done++;
    endtask

    // Inputs already set; model the coming edge, take it, check 2 time units later.
    task automatic tick();
        model_edge(cyc + 1);
        @(posedge clock);
        #2;
        compare();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic drive_pixel(input int unsigned x, input int unsigned y, input bit hb);
        ppu_valid = 1'b1; ppu_pixel = pixval(x, y); ppu_hblank = hb; ppu_vblank = 1'b0;
        tick();
    endtask

    task automatic idle_slots(input int n, input bit hb, input bit vb);
        ppu_valid = 1'b0; ppu_hblank = hb; ppu_vblank = vb;
        repeat (n) tick();
    endtask

    task automatic end_line();
        idle_slots(2, 1'b1, 1'b0);
        idle_slots(1, 1'b0, 1'b0);
    endtask

    task automatic drive_line(input int unsigned y, input int unsigned x0, input int unsigned x1);
        for (int unsigned x = x0; x < x1; x++) drive_pixel(x, y, 1'b0);
        end_line();
    endtask

    task automatic vblank_pulse();
        idle_slots(3, 1'b0, 1'b1);
        idle_slots(2, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dbuf_bus"}, 32'({fb1.fb_write_en, fb1.fb_write_addr, fb1.fb_write_data}), 32'd0);
        check({tag, "_dbuf_status"}, 32'({front1, done1, count1, eov1, esf1}), 32'd0);
        check({tag, "_sbuf_bus"}, 32'({fb2.fb_write_en, fb2.fb_write_addr, fb2.fb_write_data}), 32'd0);
        check({tag, "_sbuf_status"}, 32'({front2, done2, count2, eov2, esf2}), 32'd0);
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        idle_slots(3, 1'b0, 1'b0);
        check_all_zero("reset");
        reset = 1'b0;
        ppu_lcdEnable = 1'b1;
        tick();

        // Partial first frame is discarded
        n_wr = 0;
        for (int unsigned y = 0; y < 3; y++) drive_line(y, 0, W);
        vblank_pulse();
        check("discarded_frame_writes", 32'(n_wr), 32'd0);

        // Full frame with a coincident hblank on line 5 and an overflow on line 10
        n_wr = 0; n_done = 0;
        for (int unsigned y = 0; y < H; y++) begin
            if (y == 5) begin
                for (int unsigned x = 0; x < 158; x++) drive_pixel(x, y, 1'b0);
                drive_pixel(158, y, 1'b1);
                drive_pixel(159, y, 1'b1);
                check("coincident_addr_dbuf", 32'(fb1.fb_write_addr), 32'h1059F);
                check("coincident_addr_sbuf", 32'(fb2.fb_write_addr), 32'h059F);
                idle_slots(1, 1'b1, 1'b0);
                idle_slots(1, 1'b0, 1'b0);
            end else if (y == 6) begin
                drive_pixel(0, y, 1'b0);
                check("next_row_addr_dbuf", 32'(fb1.fb_write_addr), 32'h10600);
                check("next_row_en", 32'(fb1.fb_write_en), 32'd1);
                drive_line(y, 1, W);
            end else if (y == 10) begin
                for (int unsigned x = 0; x < W; x++) drive_pixel(x, y, 1'b0);
                check("overflow_before", 32'(eov1), 32'd0);
                drive_pixel(W, y, 1'b0);
                check("overflow_flag", 32'(eov1), 32'd1);
                check("overflow_no_write", 32'(fb1.fb_write_en), 32'd0);
                end_line();
            end else begin
                drive_line(y, 0, W);
            end
        end
        check("frame_writes", 32'(n_wr), 32'(N));
        vblank_pulse();
        check("frame_done_pulses", 32'(n_done), 32'd1);
        check("front_after_frame", 32'(front1), 32'd1);
        check("count_after_frame", 32'(count1), 32'd1);
        check("front_single_buffer", 32'(front2), 32'd0);

        // Short frame: only 100 lines before vblank
        for (int unsigned y = 0; y < 100; y++) drive_line(y, 0, W);
        vblank_pulse();
        check("short_frame_flag", 32'(esf1), 32'd1);
        check("short_frame_front", 32'(front1), 32'd1);
        check("short_frame_count", 32'(count1), 32'd1);

        // LCD drops mid-frame: clear sweep with PPU noise that must be ignored
        drive_line(0, 0, W);
        for (int unsigned x = 0; x < 50; x++) drive_pixel(x, 1, 1'b0);
        ppu_valid = 1'b0; ppu_lcdEnable = 1'b0;
        n_wr = 0; n_wr3 = 0; n_done = 0;
        tick();
        for (int i = 0; i < int'(N) + 1; i++) begin
            ppu_valid  = 1'b1;
            ppu_pixel  = 2'($urandom_range(0, 2));
            ppu_hblank = (i % 170) >= 160;
            ppu_vblank = (i % 5000) < 10;
            tick();
        end
        check("clear_writes", 32'(n_wr), 32'(N));
        check("clear_data3_writes", 32'(n_wr3), 32'(N));
        check("clear_done_pulses", 32'(n_done), 32'd1);
        check("clear_front", 32'(front1), 32'd0);
        check("clear_count", 32'(count1), 32'd1);

        // Idle afterwards: pixels and vblank ignored
        for (int unsigned x = 0; x < 20; x++) drive_pixel(x, 0, 1'b0);
        vblank_pulse();
        check("idle_no_writes", 32'(n_wr), 32'(N));

        // Reset in the middle of a clear sweep
        ppu_lcdEnable = 1'b1;
        idle_slots(1, 1'b0, 1'b0);
        ppu_lcdEnable = 1'b0;
        idle_slots(1, 1'b0, 1'b0);
        for (int unsigned x = 0; x < 40; x++) drive_pixel(x, 0, 1'b0);
        check("mid_clear_writing", 32'(fb1.fb_write_en), 32'd1);
        reset = 1'b1;
        idle_slots(1, 1'b0, 1'b0);
        check_all_zero("reset_in_clear");
        reset = 1'b0;
        n_wr = 0;
        for (int unsigned x = 0; x < 10; x++) drive_pixel(x, 0, 1'b0);
        check("after_reset_idle", 32'(n_wr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
